// File: rtl/ibex_wb_arbiter_if.sv
// Writeback arbiter bus bundle: execute issue, LSU response, register file
// write port and decode operand read/forward signals.
interface ibex_wb_arbiter_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 ex_valid_i;
  logic                 ex_ready_o;
  logic                 ex_is_load_i;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 lsu_rvalid_i;
  logic [DataWidth-1:0] lsu_rdata_i;
  logic                 lsu_err_i;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 rf_we_o;
  logic [4:0]           raddr_a_i;
  logic [4:0]           raddr_b_i;
  logic [DataWidth-1:0] rf_rdata_a_i;
  logic [DataWidth-1:0] rf_rdata_b_i;
  logic [DataWidth-1:0] rdata_a_o;
  logic [DataWidth-1:0] rdata_b_o;
  logic                 load_hazard_o;
  logic                 lsu_unexpected_o;

  // Arbiter side
  modport slave (
    input  ex_valid_i, ex_is_load_i, ex_waddr_i, ex_wdata_i,
    input  lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    input  raddr_a_i, raddr_b_i, rf_rdata_a_i, rf_rdata_b_i,
    output ex_ready_o, rf_waddr_o, rf_wdata_o, rf_we_o,
    output rdata_a_o, rdata_b_o, load_hazard_o, lsu_unexpected_o
  );

  // Pipeline / register file side
  modport master (
    output ex_valid_i, ex_is_load_i, ex_waddr_i, ex_wdata_i,
    output lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    output raddr_a_i, raddr_b_i, rf_rdata_a_i, rf_rdata_b_i,
    input  ex_ready_o, rf_waddr_o, rf_wdata_o, rf_we_o,
    input  rdata_a_o, rdata_b_o, load_hazard_o, lsu_unexpected_o
  );
endinterface

// File: rtl/ibex_wb_arbiter.sv
// Writeback arbiter: merges execute results and LSU load responses onto the
// single register file write port. Pending load destinations live in a small
// FIFO; an execute write that loses to a load response waits in a one-entry
// skid. Optional macro WB_FORWARD_EN enables operand forwarding from the skid
// and the output register; without it those cases raise load_hazard_o.
module ibex_wb_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LoadDepth = 2
) (
  input logic            clk_i,
  input logic            rst_ni,
  ibex_wb_arbiter_if.slave bus
);
  localparam int unsigned PtrW = (LoadDepth > 1) ? $clog2(LoadDepth) : 1;

  logic [LoadDepth-1:0][4:0] fifo_addr;
  logic [LoadDepth-1:0]      fifo_vld;
  logic [PtrW-1:0]           wptr, rptr;
  logic                      fifo_full, fifo_empty;
  logic [4:0]                head;

  logic                 skid_vld;
  logic [4:0]           skid_addr;
  logic [DataWidth-1:0] skid_data;

  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [DataWidth-1:0] rf_wdata;
  logic                 unexpected;

  logic waw_hit, fifo_hit_a, fifo_hit_b;
  logic accept, ex_wr, push, pop;
  logic                 sel_we, skid_load, skid_drain;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_data;

  assign fifo_full  = &fifo_vld;
  assign fifo_empty = ~|fifo_vld;
  assign head       = fifo_addr[rptr];

  // Address matches against the pending-load FIFO (x0 never matches)
  always_comb begin
    waw_hit    = 1'b0;
    fifo_hit_a = 1'b0;
    fifo_hit_b = 1'b0;
    for (int i = 0; i < int'(LoadDepth); i++) begin
      if (fifo_vld[i] && fifo_addr[i] == bus.ex_waddr_i && bus.ex_waddr_i != 5'd0) waw_hit = 1'b1;
      if (fifo_vld[i] && fifo_addr[i] == bus.raddr_a_i && bus.raddr_a_i != 5'd0)   fifo_hit_a = 1'b1;
      if (fifo_vld[i] && fifo_addr[i] == bus.raddr_b_i && bus.raddr_b_i != 5'd0)   fifo_hit_b = 1'b1;
    end
  end

  assign bus.ex_ready_o = !skid_vld && !(bus.ex_is_load_i && fifo_full) && !waw_hit;
  assign accept = bus.ex_valid_i && bus.ex_ready_o;
  assign ex_wr  = accept && !bus.ex_is_load_i && (bus.ex_waddr_i != 5'd0);
  assign push   = accept && bus.ex_is_load_i;
  assign pop    = bus.lsu_rvalid_i && !fifo_empty;

  // Write port selection: LSU response, then skid, then new execute write.
  // Any response claims the port, so a same-cycle execute write is skidded.
  always_comb begin
    sel_we     = 1'b0;
    sel_addr   = '0;
    sel_data   = '0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (bus.lsu_rvalid_i) begin
      if (!fifo_empty && !bus.lsu_err_i && head != 5'd0) begin
        sel_we   = 1'b1;
        sel_addr = head;
        sel_data = bus.lsu_rdata_i;
      end
      skid_load = ex_wr;
    end else if (skid_vld) begin
      sel_we     = 1'b1;
      sel_addr   = skid_addr;
      sel_data   = skid_data;
      skid_drain = 1'b1;
    end else if (ex_wr) begin
      sel_we   = 1'b1;
      sel_addr = bus.ex_waddr_i;
      sel_data = bus.ex_wdata_i;
    end
  end

  // Pending-load FIFO; pointers wrap naturally since LoadDepth is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_addr <= '0;
      fifo_vld  <= '0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      if (pop) begin
        fifo_vld[rptr] <= 1'b0;
        rptr           <= rptr + PtrW'(1);
      end
      if (push) begin
        fifo_addr[wptr] <= bus.ex_waddr_i;
        fifo_vld[wptr]  <= 1'b1;
        wptr            <= wptr + PtrW'(1);
      end
    end
  end

  // Skid buffer for an execute write displaced by a load response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_vld  <= 1'b0;
      skid_addr <= '0;
      skid_data <= '0;
    end else if (skid_load) begin
      skid_vld  <= 1'b1;
      skid_addr <= bus.ex_waddr_i;
      skid_data <= bus.ex_wdata_i;
    end else if (skid_drain) begin
      skid_vld  <= 1'b0;
    end
  end

  // Registered write port and unexpected-response pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      unexpected <= 1'b0;
    end else begin
      rf_we      <= sel_we;
      unexpected <= bus.lsu_rvalid_i && fifo_empty;
      if (sel_we) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  assign bus.rf_we_o          = rf_we;
  assign bus.rf_waddr_o       = rf_waddr;
  assign bus.rf_wdata_o       = rf_wdata;
  assign bus.lsu_unexpected_o = unexpected;

`ifdef WB_FORWARD_EN
  // Operand forwarding: skid is youngest, then the output register
  always_comb begin
    bus.rdata_a_o = bus.rf_rdata_a_i;
    bus.rdata_b_o = bus.rf_rdata_b_i;
    if (bus.raddr_a_i == 5'd0)                         bus.rdata_a_o = '0;
    else if (skid_vld && skid_addr == bus.raddr_a_i)   bus.rdata_a_o = skid_data;
    else if (rf_we && rf_waddr == bus.raddr_a_i)       bus.rdata_a_o = rf_wdata;
    if (bus.raddr_b_i == 5'd0)                         bus.rdata_b_o = '0;
    else if (skid_vld && skid_addr == bus.raddr_b_i)   bus.rdata_b_o = skid_data;
    else if (rf_we && rf_waddr == bus.raddr_b_i)       bus.rdata_b_o = rf_wdata;
  end
  assign bus.load_hazard_o = fifo_hit_a || fifo_hit_b;
`else
  logic late_a, late_b;

  // No forwarding: in-flight writes to an operand become hazards instead
  always_comb begin
    bus.rdata_a_o = (bus.raddr_a_i == 5'd0) ? '0 : bus.rf_rdata_a_i;
    bus.rdata_b_o = (bus.raddr_b_i == 5'd0) ? '0 : bus.rf_rdata_b_i;
    late_a = (bus.raddr_a_i != 5'd0) &&
             ((skid_vld && skid_addr == bus.raddr_a_i) || (rf_we && rf_waddr == bus.raddr_a_i));
    late_b = (bus.raddr_b_i != 5'd0) &&
             ((skid_vld && skid_addr == bus.raddr_b_i) || (rf_we && rf_waddr == bus.raddr_b_i));
  end
  assign bus.load_hazard_o = fifo_hit_a || fifo_hit_b || late_a || late_b;
`endif
endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// Self-checking bench for ibex_wb_arbiter: directed test-plan scenarios then
// randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_ibex_wb_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errs = 0;

  ibex_wb_arbiter_if #(.DataWidth(DW)) bus();

  ibex_wb_arbiter #(.DataWidth(DW), .LoadDepth(DEPTH)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [4:0]    pend[$];
  bit            sk_v;
  logic [4:0]    sk_a;
  logic [DW-1:0] sk_d;
  bit            m_we, m_unexp;
  logic [4:0]    m_waddr;
  logic [DW-1:0] m_wdata;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pending(input logic [4:0] a);
    foreach (pend[i]) if (pend[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit late_write(input logic [4:0] a);
    return (sk_v && sk_a == a) || (m_we && m_waddr == a);
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic [4:0] a, input logic [DW-1:0] rf);
    if (a == 0) return '0;
`ifdef WB_FORWARD_EN
    if (sk_v && sk_a == a) return sk_d;
    if (m_we && m_waddr == a) return m_wdata;
`endif
    return rf;
  endfunction

  function automatic bit exp_hazard(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef WB_FORWARD_EN
    return pending(a);
`else
    return pending(a) || late_write(a);
`endif
  endfunction

  task automatic model_reset();
    pend.delete();
    sk_v = 0; sk_a = '0; sk_d = '0;
    m_we = 0; m_unexp = 0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic idle_inputs();
    bus.ex_valid_i = 0; bus.ex_is_load_i = 0; bus.ex_waddr_i = '0; bus.ex_wdata_i = '0;
    bus.lsu_rvalid_i = 0; bus.lsu_rdata_i = '0; bus.lsu_err_i = 0;
    bus.raddr_a_i = '0; bus.raddr_b_i = '0; bus.rf_rdata_a_i = '0; bus.rf_rdata_b_i = '0;
  endtask

  // One clock: check every output against the model mid-cycle, advance the model
  task automatic step();
    bit rdy, acc, wr;
    logic [4:0] a;
    @(negedge clk);
    rdy = !sk_v && !(bus.ex_is_load_i && pend.size() == DEPTH) &&
          !(bus.ex_waddr_i != 0 && pending(bus.ex_waddr_i));
    chk("ready", bus.ex_ready_o, rdy);
    chk("hazard", bus.load_hazard_o, exp_hazard(bus.raddr_a_i) || exp_hazard(bus.raddr_b_i));
    chk("rdata_a", bus.rdata_a_o, exp_rdata(bus.raddr_a_i, bus.rf_rdata_a_i));
    chk("rdata_b", bus.rdata_b_o, exp_rdata(bus.raddr_b_i, bus.rf_rdata_b_i));
    chk("we", bus.rf_we_o, m_we);
    chk("unexpected", bus.lsu_unexpected_o, m_unexp);
    if (m_we) begin
      chk("waddr", bus.rf_waddr_o, m_waddr);
      chk("wdata", bus.rf_wdata_o, m_wdata);
    end
    acc = bus.ex_valid_i && rdy;
    wr  = acc && !bus.ex_is_load_i && bus.ex_waddr_i != 0;
    m_we = 0; m_unexp = 0;
    if (bus.lsu_rvalid_i) begin
      if (pend.size() == 0) m_unexp = 1;
      else begin
        a = pend.pop_front();
        if (!bus.lsu_err_i && a != 0) begin m_we = 1; m_waddr = a; m_wdata = bus.lsu_rdata_i; end
      end
      if (wr) begin sk_v = 1; sk_a = bus.ex_waddr_i; sk_d = bus.ex_wdata_i; end
    end else if (sk_v) begin
      m_we = 1; m_waddr = sk_a; m_wdata = sk_d; sk_v = 0;
    end else if (wr) begin
      m_we = 1; m_waddr = bus.ex_waddr_i; m_wdata = bus.ex_wdata_i;
    end
    if (acc && bus.ex_is_load_i) pend.push_back(bus.ex_waddr_i);
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input bit ld, input logic [4:0] a, input logic [DW-1:0] d);
    bus.ex_valid_i = 1; bus.ex_is_load_i = ld; bus.ex_waddr_i = a; bus.ex_wdata_i = d;
  endtask

  task automatic rsp(input logic [DW-1:0] d, input bit err);
    bus.lsu_rvalid_i = 1; bus.lsu_rdata_i = d; bus.lsu_err_i = err;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_we", bus.rf_we_o, 0);
    chk("rst_waddr", bus.rf_waddr_o, 0);
    chk("rst_wdata", bus.rf_wdata_o, 0);
    chk("rst_unexp", bus.lsu_unexpected_o, 0);
    chk("rst_ready", bus.ex_ready_o, 1);

    // ALU write appears exactly one cycle later, x0 writes nothing
    ex(0, 5'd5, 32'h1234); step(); idle_inputs();
    chk("alu_we", bus.rf_we_o, 1);
    chk("alu_waddr", bus.rf_waddr_o, 5);
    chk("alu_wdata", bus.rf_wdata_o, 32'h1234);
    ex(0, 5'd0, 32'hFFFF); step(); idle_inputs();
    chk("alu_we_x0", bus.rf_we_o, 0);
    step();

    // Load x7, response three cycles later, hazard until then
    ex(1, 5'd7, 0); step(); idle_inputs();
    bus.raddr_a_i = 5'd7;
    #1 chk("ld_hazard", bus.load_hazard_o, 1);
    step(); step();
    rsp(32'hDEADBEEF, 0); step(); idle_inputs();
    chk("ld_we", bus.rf_we_o, 1);
    chk("ld_waddr", bus.rf_waddr_o, 7);
    chk("ld_wdata", bus.rf_wdata_o, 32'hDEADBEEF);
    step();

    // Collision: response for x3 and ex write x4 in the same cycle
    ex(1, 5'd3, 0); step(); idle_inputs(); step();
    rsp(32'hAA, 0); ex(0, 5'd4, 32'hBB);
    #1 chk("col_ready_pre", bus.ex_ready_o, 1);
    step(); idle_inputs();
    chk("col_first", bus.rf_waddr_o, 3);
    chk("col_ready_skid", bus.ex_ready_o, 0);
    step();
    chk("col_second", bus.rf_waddr_o, 4);
    chk("col_second_d", bus.rf_wdata_o, 32'hBB);
    chk("col_ready_after", bus.ex_ready_o, 1);

    // FIFO full and WAW stall
    ex(1, 5'd1, 0); step(); ex(1, 5'd2, 0); step();
    ex(1, 5'd3, 0);
    #1 chk("full_stall", bus.ex_ready_o, 0);
    step();
    ex(0, 5'd1, 32'h77);
    #1 chk("waw_stall", bus.ex_ready_o, 0);
    step();
    ex(1, 5'd3, 0); rsp(32'h101, 0); step();
    bus.lsu_rvalid_i = 0;
    #1 chk("full_release", bus.ex_ready_o, 1);
    step(); idle_inputs();

    // Error response pops without writing, then drain and an unexpected response
    rsp(32'h5A5A, 1); step(); idle_inputs();
    chk("err_no_we", bus.rf_we_o, 0);
    rsp(32'h303, 0); step(); idle_inputs(); step();
    rsp(32'h999, 0); step(); idle_inputs();
    chk("unexp_pulse", bus.lsu_unexpected_o, 1);
    chk("unexp_no_we", bus.rf_we_o, 0);
    step();
    chk("unexp_clear", bus.lsu_unexpected_o, 0);

    // Skid holds x9 while operand A reads x9
    ex(1, 5'd8, 0); step(); idle_inputs();
    rsp(32'h808, 0); ex(0, 5'd9, 32'h55); step(); idle_inputs();
    bus.raddr_a_i = 5'd9; bus.rf_rdata_a_i = 32'h11;
    #1;
`ifdef WB_FORWARD_EN
    chk("fwd_skid", bus.rdata_a_o, 32'h55);
    chk("fwd_hazard", bus.load_hazard_o, 0);
`else
    chk("nofwd_data", bus.rdata_a_o, 32'h11);
    chk("nofwd_hazard", bus.load_hazard_o, 1);
`endif
    step(); idle_inputs(); step();

    // Reset mid-load clears the write port at once; late response is unexpected
    ex(1, 5'd7, 0); step(); ex(0, 5'd6, 32'h66); step(); idle_inputs();
    chk("pre_rst_we", bus.rf_we_o, 1);
    rst_n = 1'b0;
    #1 chk("async_rst_we", bus.rf_we_o, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rsp(32'h77, 0); step(); idle_inputs();
    chk("post_rst_unexp", bus.lsu_unexpected_o, 1);
    step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      bus.ex_valid_i   = ($urandom_range(0, 9) < 7);
      bus.ex_is_load_i = ($urandom_range(0, 9) < 3);
      bus.ex_waddr_i   = 5'($urandom_range(0, 7));
      bus.ex_wdata_i   = $urandom;
      bus.lsu_rvalid_i = (pend.size() != 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      bus.lsu_rdata_i  = $urandom;
      bus.lsu_err_i    = ($urandom_range(0, 9) < 2);
      bus.raddr_a_i    = 5'($urandom_range(0, 7));
      bus.raddr_b_i    = 5'($urandom_range(0, 7));
      bus.rf_rdata_a_i = $urandom;
      bus.rf_rdata_b_i = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
